// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial adder.
// The requester drives operands and start; the sequencer returns status and result.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             Cout;

    modport master (
        output start,
        output A,
        output B,
        output Cin,
        input  busy,
        input  done,
        input  SUM,
        input  Cout
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        input  Cin,
        output busy,
        output done,
        output SUM,
        output Cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full_adder cell, LSB first, one bit per clock.
// Operands are captured on accept; result and carry-out update once per op.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_nxt;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
    assign res_nxt = {fa_s, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        a_sr   <= bus.A;
                        b_sr   <= bus.B;
                        carry  <= bus.Cin;
                        cnt    <= '0;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    carry  <= fa_co;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        sum_q  <= res_nxt;
                        cout_q <= fa_co;
                        cnt    <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.SUM  = sum_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of the bit-serial adder against A+B+Cin.
// Expected timing and results come from arithmetic on the applied operands.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [W:0]   last_res;
    logic [W:0]   exp_res;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    int           gap;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    // inj: RUN cycle at which a stray start is pulsed (0 = none)
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input int inj, input string tag);
        logic [W:0] e;
        e = model(x, y, ci);
        bus.A = x;
        bus.B = y;
        bus.Cin = ci;
        bus.start = 1'b1;
        tick;
        for (int i = 1; i <= W; i++) begin
            check({tag, "_run_bd"}, 64'({bus.busy, bus.done}), 64'(2'b10));
            check({tag, "_hold"}, 64'({bus.Cout, bus.SUM}), 64'(last_res));
            bus.start = (i == inj);
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.Cin = 1'($urandom);
            tick;
        end
        bus.start = 1'b0;
        check({tag, "_done_bd"}, 64'({bus.busy, bus.done}), 64'(2'b01));
        check({tag, "_res"}, 64'({bus.Cout, bus.SUM}), 64'(e));
        last_res = e;
        tick;
        check({tag, "_post_bd"}, 64'({bus.busy, bus.done}), 64'(2'b00));
        check({tag, "_post_res"}, 64'({bus.Cout, bus.SUM}), 64'(e));
    endtask

    initial begin
        bus.start = 1'b1;
        bus.A = 8'hAA;
        bus.B = 8'h55;
        bus.Cin = 1'b1;
        last_res = '0;

        // reset held two cycles while start is asserted
        rst_n = 1'b0;
        tick;
        tick;
        check("rst_bd", 64'({bus.busy, bus.done}), 64'(2'b00));
        check("rst_res", 64'({bus.Cout, bus.SUM}), 64'(0));
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick;
        check("rel_bd", 64'({bus.busy, bus.done}), 64'(2'b00));
        check("rel_res", 64'({bus.Cout, bus.SUM}), 64'(0));
        for (int i = 0; i < 20; i++) begin
            tick;
            check("idle", 64'({bus.busy, bus.done, bus.Cout, bus.SUM}), 64'(0));
        end

        run_op(8'h5A, 8'h3C, 1'b0, 0, "t2");
        run_op(8'hFF, 8'h01, 1'b0, 0, "t3a");
        run_op(8'hFF, 8'hFF, 1'b1, 0, "t3b");
        run_op(8'h10, 8'h20, 1'b0, 3, "t4");

        // reset in the middle of an operation
        bus.A = 8'hC3;
        bus.B = 8'h7E;
        bus.Cin = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        check("t5_pre_busy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("t5_rst_bd", 64'({bus.busy, bus.done}), 64'(2'b00));
        check("t5_rst_res", 64'({bus.Cout, bus.SUM}), 64'(0));
        last_res = '0;
        for (int i = 0; i < 12; i++) begin
            tick;
            check("t5_nodone", 64'({bus.busy, bus.done}), 64'(2'b00));
        end
        run_op(8'h81, 8'h7F, 1'b1, 0, "t5_new");

        // start held high: back-to-back operations
        bus.start = 1'b1;
        for (int op = 0; op < 1003; op++) begin
            if (op < 3) begin
                a = 8'h01;
                b = 8'h01;
                c = 1'b1;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
                c = 1'($urandom);
            end
            bus.A = a;
            bus.B = b;
            bus.Cin = c;
            exp_res = model(a, b, c);
            gap = 0;
            do begin
                tick;
                gap++;
            end while (!bus.done && gap < 40);
            check("t6_gap", 64'(gap), 64'(W + 1));
            check("t6_res", 64'({bus.busy, bus.Cout, bus.SUM}), 64'(exp_res));
        end
        bus.start = 1'b0;
        tick;
        tick;
        check("t6_idle_bd", 64'({bus.busy, bus.done}), 64'(2'b00));
        check("t6_idle_res", 64'({bus.Cout, bus.SUM}), 64'(exp_res));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
